// File: rtl/direction_if.sv
// Button, game-step and direction signals between the board/game-state side
// and direction_ctrl. The master drives buttons and step pulses.
interface direction_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       tick;
    logic       g_over;
    logic [3:0] direction;
    logic       turn_pending;
    logic       dropped;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, tick, g_over,
        input  direction, turn_pending, dropped
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, tick, g_over,
        output direction, turn_pending, dropped
    );
endinterface

// File: rtl/direction_ctrl.sv
// Debounces four push-buttons and turns presses into a one-hot snake direction,
// buffering up to two pending turns and applying one per game tick.
module direction_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic       clk,
    input  logic       rst,
    direction_if.slave bus
);
    // Bit order everywhere: {left, right, up, down}
    logic [3:0] btn_raw;
    assign btn_raw = {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};

    logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]      db_q, db_d, db_prev_q, db_prev_d;
    logic [3:0]      arm_q, arm_d;
    logic [1:0]      warm_q, warm_d;
    logic [DB_W-1:0] cnt_q [4];
    logic [DB_W-1:0] cnt_d [4];
    logic [3:0]      que_q [2];
    logic [3:0]      que_d [2];
    logic [1:0]      count_q, count_d;
    logic [3:0]      dir_q, dir_d;
    logic            pend_q, pend_d, drop_q, drop_d;

    logic [3:0] rise, win, losers, ref_dir, opp_dir;
    logic       reject, accept, pop, push;

    // A button only produces presses after it has been seen released since
    // reset, so buttons held through reset do not generate a turn.
    always_comb begin
        // NOTE: every _d signal gets a default before any branch so no latch is inferred.
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        arm_d     = arm_q;
        warm_d    = {warm_q[0], 1'b1};
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
            if (warm_q[1] && !sync2_q[i]) begin
                arm_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rise = db_q & ~db_prev_q & arm_q;
        win  = 4'b0000;
        if (rise[3])      win = 4'b1000;
        else if (rise[2]) win = 4'b0100;
        else if (rise[1]) win = 4'b0010;
        else if (rise[0]) win = 4'b0001;
        losers = rise & ~win;

        // Reference is sampled before any same-cycle pop.
        ref_dir = dir_q;
        if (count_q == 2'd2)      ref_dir = que_q[1];
        else if (count_q == 2'd1) ref_dir = que_q[0];
        opp_dir = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};

        reject = (win != 4'b0000) && (ref_dir != 4'b0000) &&
                 ((win == ref_dir) || (win == opp_dir));
        accept = (win != 4'b0000) && !reject;
        pop    = bus.tick && (count_q != 2'd0) && !bus.g_over;
        push   = accept && ((count_q != 2'd2) || pop) && !bus.g_over;

        dir_d   = dir_q;
        que_d   = que_q;
        count_d = count_q;
        drop_d  = 1'b0;
        if (bus.g_over) begin
            count_d = 2'd0;
        end else begin
            drop_d = (losers != 4'b0000) || ((win != 4'b0000) && !push);
            if (pop) begin
                dir_d    = que_q[0];
                que_d[0] = que_q[1];
                count_d  = count_q - 2'd1;
            end
            if (push) begin
                que_d[count_d[0]] = win;
                count_d           = count_d + 2'd1;
            end
        end
        pend_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            arm_q     <= '0;
            warm_q    <= '0;
            // NOTE: the two queue slots are cleared too; they are plain flops, not a RAM.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) que_q[i] <= '0;
            count_q   <= '0;
            dir_q     <= '0;
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            arm_q     <= arm_d;
            warm_q    <= warm_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            for (int i = 0; i < 2; i++) que_q[i] <= que_d[i];
            count_q   <= count_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.direction    = dir_q;
    assign bus.turn_pending = pend_q;
    assign bus.dropped      = drop_q;
endmodule
